ecall_ctrl: RTL and testbench
=============================

ECALL_CTRL -- requirements
Module: ecall_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 1024, io_ack wait limit in cycles (used only with ECALL_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 ecall_valid  in  1  decode stage holds an ecall instruction.
REQ-005 a0_data  in  32  current x10 value (argument).
REQ-006 a7_data  in  32  current x17 value (service number).
REQ-007 stall  out  1  freeze fetch/decode while high.
REQ-008 ecall_write  out  1  one-cycle write strobe of ecall_result into x10.
REQ-009 ecall_result  out  32  value for x10.
REQ-010 io_req  out  1  IO request, held until io_ack.
REQ-011 io_op  out  2  00 print int, 01 read int, 10 print char, 11 read char.
REQ-012 io_wdata  out  32  write payload.
REQ-013 io_ack  in  1  IO completion; io_rdata valid in same cycle.
REQ-014 io_rdata  in  32  read payload.
REQ-015 halted  out  1  sticky, exit service executed.
REQ-016 bad_call  out  1  sticky, unknown service seen.

Function
REQ-017 States IDLE, REQ, WB, DONE, HALT.
REQ-018 IDLE & ecall_valid: latch a0_data/a7_data; a7=10 -> HALT; a7 in {1,5,11,12} -> REQ; other -> DONE, set bad_call.
REQ-019 Service map: 1->op 00, io_wdata=a0; 5->op 01; 11->op 10, io_wdata={24'b0,a0[7:0]}; 12->op 11.
REQ-020 REQ: io_req=1, io_op/io_wdata stable; on io_ack: read ops capture result -> WB, write ops -> DONE; no ack -> stay.
REQ-021 Read int result = io_rdata; read char result = {24'b0,io_rdata[7:0]}.
REQ-022 WB: ecall_write=1 exactly one cycle, ecall_result=captured value; -> DONE.
REQ-023 DONE: stall=0, ecall_valid ignored, -> IDLE next cycle (pipeline retires the ecall here).
REQ-024 stall = (IDLE & ecall_valid) | REQ | WB | HALT, combinational.
REQ-025 Minimum latency: write service, io_ack in first REQ cycle -> stall high 2 cycles; read service -> 3 cycles.
REQ-026 HALT absorbing until rst; io_req=0, ecall_write=0, stall=1.
REQ-027 io_ack outside REQ ignored; io_rdata ignored except when io_ack in REQ.
REQ-028 ecall_write takes priority over normal register write in the same cycle (register file contract).

Reset
REQ-029 rst sampled high: state IDLE, stall=0 (unless combinationally driven by ecall_valid next cycle), io_req=0, ecall_write=0, ecall_result=0, io_wdata=0, io_op=00, halted=0, bad_call=0.
REQ-030 rst mid-operation aborts with no x10 write and io_req low the next cycle.

Configuration
REQ-031 Macro ECALL_TIMEOUT_EN defined: counter clears on REQ entry, counts in REQ; reaching TIMEOUT_CYCLES without io_ack -> drop io_req, set sticky timeout output (1 bit), read ops write 32'hFFFF_FFFF via WB, write ops go to DONE.
REQ-032 Undefined: no counter, no timeout port, REQ waits indefinitely.

Structure
REQ-033 Package ecall_pkg: state enum, io_op enum, service-number constants (1,5,10,11,12).
REQ-034 Sub-module ecall_watchdog (counter + expiry flag), instantiated only under ECALL_TIMEOUT_EN.

Verification
REQ-035 a7=11, a0=0x141, io_ack 3 cycles after io_req -> io_op=10, io_wdata=0x41, stall 5 cycles, no ecall_write.
REQ-036 a7=5, io_ack with io_rdata=0xFFFF_FFF6 -> ecall_write one cycle, ecall_result=0xFFFF_FFF6, then DONE.
REQ-037 a7=12, io_rdata=0x1234_5678 -> ecall_result=0x0000_0078.
REQ-038 a7=10 -> halted=1, stall stays 1 for 100 cycles; rst -> IDLE, halted=0.
REQ-039 a7=99 -> bad_call=1, no io_req, stall 1 cycle; rst asserted during REQ -> io_req 0, no ecall_write.
REQ-040 ECALL_TIMEOUT_EN, TIMEOUT_CYCLES=8, a7=5, no ack -> timeout=1, ecall_result=0xFFFF_FFFF after 8 REQ cycles.

Source files
------------

// File: rtl/ecall_pkg.sv
// ============================================================================
// Module  : ecall_pkg
// Purpose : Shared types and service numbers for the ecall controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package ecall_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WB   = 3'd2,
    ST_DONE = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_PRINT_INT  = 2'b00,
    OP_READ_INT   = 2'b01,
    OP_PRINT_CHAR = 2'b10,
    OP_READ_CHAR  = 2'b11
  } io_op_t;

  localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SVC_READ_INT   = 32'd5;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SVC_READ_CHAR  = 32'd12;

  // Read services are the odd op codes; they return a value into x10.
  function automatic logic op_is_read(input io_op_t op);
    return op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ecall_watchdog.sv
// ============================================================================
// Module  : ecall_watchdog
// Purpose : Counts consecutive REQ cycles; flags expiry on the last allowed one.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ecall_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Leaving REQ zeroes the count, so every REQ entry starts fresh.
  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/ecall_ctrl.sv
// ============================================================================
// Module  : ecall_ctrl
// Purpose : Executes ecall services (print/read int/char, exit) over an IO
//           handshake, stalling the front end and writing results to x10.
//           Optional io_ack timeout under macro ECALL_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ecall_ctrl
  import ecall_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_valid,
  input  logic [31:0] a0_data,
  input  logic [31:0] a7_data,
  output logic        stall,
  output logic        ecall_write,
  output logic [31:0] ecall_result,
  output logic        io_req,
  output logic [1:0]  io_op,
  output logic [31:0] io_wdata,
  input  logic        io_ack,
  input  logic [31:0] io_rdata,
`ifdef ECALL_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic        halted,
  output logic        bad_call
);

  state_t      state_q, state_d;
  io_op_t      op_q, op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic        halted_q, halted_d;
  logic        bad_call_q, bad_call_d;
  logic        in_req;
  logic        wd_expired;

  assign in_req = (state_q == ST_REQ);

`ifdef ECALL_TIMEOUT_EN
  logic timeout_q, timeout_d;

  ecall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    (in_req),
    .expired(wd_expired)
  );

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_PRINT_INT;
      wdata_q    <= '0;
      result_q   <= '0;
      halted_q   <= 1'b0;
      bad_call_q <= 1'b0;
`ifdef ECALL_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
      halted_q   <= halted_d;
      bad_call_q <= bad_call_d;
`ifdef ECALL_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    halted_d   = halted_q;
    bad_call_d = bad_call_q;
`ifdef ECALL_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ecall_valid) begin
          state_d = ST_REQ;
          wdata_d = '0;
          if (a7_data == SVC_EXIT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (a7_data == SVC_PRINT_INT) begin
            op_d    = OP_PRINT_INT;
            wdata_d = a0_data;
          end else if (a7_data == SVC_READ_INT) begin
            op_d = OP_READ_INT;
          end else if (a7_data == SVC_PRINT_CHAR) begin
            op_d    = OP_PRINT_CHAR;
            wdata_d = {24'b0, a0_data[7:0]};
          end else if (a7_data == SVC_READ_CHAR) begin
            op_d = OP_READ_CHAR;
          end else begin
            state_d    = ST_DONE;
            bad_call_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (io_ack) begin
          if (op_is_read(op_q)) begin
            result_d = (op_q == OP_READ_CHAR) ? {24'b0, io_rdata[7:0]} : io_rdata;
            state_d  = ST_WB;
          end else begin
            state_d = ST_DONE;
          end
        end else if (wd_expired) begin
`ifdef ECALL_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
          if (op_is_read(op_q)) begin
            result_d = 32'hFFFF_FFFF;
            state_d  = ST_WB;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall       = ((state_q == ST_IDLE) && ecall_valid) || in_req ||
                  (state_q == ST_WB) || (state_q == ST_HALT);
    io_req      = in_req;
    ecall_write = (state_q == ST_WB);
  end

  assign io_op        = op_q;
  assign io_wdata     = wdata_q;
  assign ecall_result = result_q;
  assign halted       = halted_q;
  assign bad_call     = bad_call_q;

endmodule

`default_nettype wire

// File: tb/tb_ecall_ctrl.sv
// ============================================================================
// Module  : tb_ecall_ctrl
// Purpose : Directed self-checking bench for ecall_ctrl (timeout case only
//           when ECALL_TIMEOUT_EN is defined).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_ecall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ecall_valid = 1'b0;
  logic [31:0] a0_data = '0;
  logic [31:0] a7_data = '0;
  logic        stall;
  logic        ecall_write;
  logic [31:0] ecall_result;
  logic        io_req;
  logic [1:0]  io_op;
  logic [31:0] io_wdata;
  logic        io_ack = 1'b0;
  logic [31:0] io_rdata = '0;
  logic        halted;
  logic        bad_call;
`ifdef ECALL_TIMEOUT_EN
  logic        timeout;
`endif

  int total = 0;
  int bad = 0;

  int          r_stall, r_req, r_wr;
  logic [1:0]  r_op;
  logic [31:0] r_wdata, r_res;

  always #5 clk = ~clk;

  ecall_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ecall_valid (ecall_valid),
    .a0_data     (a0_data),
    .a7_data     (a7_data),
    .stall       (stall),
    .ecall_write (ecall_write),
    .ecall_result(ecall_result),
    .io_req      (io_req),
    .io_op       (io_op),
    .io_wdata    (io_wdata),
    .io_ack      (io_ack),
    .io_rdata    (io_rdata),
`ifdef ECALL_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .halted      (halted),
    .bad_call    (bad_call)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ecall_valid = 1'b0; io_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Holds ecall_valid until the DONE cycle, acks at cycle ack_cyc (cycle 0 = IDLE).
  task automatic run_call(input logic [31:0] a7, input logic [31:0] a0,
                          input int ack_cyc, input logic [31:0] rdata);
    bit fin;
    r_stall = 0; r_req = 0; r_wr = 0; r_op = 2'bxx; r_wdata = 'x; r_res = 'x;
    @(posedge clk); #1;
    ecall_valid = 1'b1; a7_data = a7; a0_data = a0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      io_ack   = (cyc == ack_cyc);
      io_rdata = (cyc == ack_cyc) ? rdata : 32'hA5A5_5A5A;
      @(negedge clk);
      if (stall) r_stall++;
      if (io_req) begin
        if (r_req == 0) begin r_op = io_op; r_wdata = io_wdata; end
        r_req++;
      end
      if (ecall_write) begin r_wr++; r_res = ecall_result; end
      fin = (cyc > 0) && !stall;
      @(posedge clk); #1;
      if (fin) break;
    end
    ecall_valid = 1'b0; io_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (stall !== 1'b0 || io_req !== 1'b0 || ecall_write !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: got stall=%b req=%b wr=%b want 0 0 0", stall, io_req, ecall_write);
    end
    total++; if (ecall_result !== 32'h0 || io_wdata !== 32'h0 || io_op !== 2'b00) begin
      bad++; $display("FAIL reset_data: got res=%h wdata=%h op=%b want 0 0 00", ecall_result, io_wdata, io_op);
    end
    total++; if (halted !== 1'b0 || bad_call !== 1'b0) begin
      bad++; $display("FAIL reset_sticky: got halted=%b bad_call=%b want 0 0", halted, bad_call);
    end
  endtask

  task automatic test_print_int();
    run_call(32'd1, 32'hCAFE_0123, 1, 32'h0);
    total++; if (r_stall !== 2) begin bad++; $display("FAIL pint_stall: got %0d want 2", r_stall); end
    total++; if (r_op !== 2'b00 || r_wdata !== 32'hCAFE_0123) begin
      bad++; $display("FAIL pint_req: got op=%b wdata=%h want 00 cafe0123", r_op, r_wdata);
    end
    total++; if (r_wr !== 0) begin bad++; $display("FAIL pint_wr: got %0d want 0", r_wr); end
  endtask

  task automatic test_print_char();
    run_call(32'd11, 32'h0000_0141, 4, 32'h0);
    total++; if (r_stall !== 5) begin bad++; $display("FAIL pchar_stall: got %0d want 5", r_stall); end
    total++; if (r_req !== 4) begin bad++; $display("FAIL pchar_req_cycles: got %0d want 4", r_req); end
    total++; if (r_op !== 2'b10 || r_wdata !== 32'h0000_0041) begin
      bad++; $display("FAIL pchar_req: got op=%b wdata=%h want 10 00000041", r_op, r_wdata);
    end
    total++; if (r_wr !== 0) begin bad++; $display("FAIL pchar_wr: got %0d want 0", r_wr); end
  endtask

  task automatic test_read_int();
    run_call(32'd5, 32'h0, 2, 32'hFFFF_FFF6);
    total++; if (r_stall !== 4) begin bad++; $display("FAIL rint_stall: got %0d want 4", r_stall); end
    total++; if (r_op !== 2'b01) begin bad++; $display("FAIL rint_op: got %b want 01", r_op); end
    total++; if (r_wr !== 1 || r_res !== 32'hFFFF_FFF6) begin
      bad++; $display("FAIL rint_wb: got wr=%0d res=%h want 1 fffffff6", r_wr, r_res);
    end
    @(negedge clk);
    total++; if (ecall_write !== 1'b0 || ecall_result !== 32'hFFFF_FFF6) begin
      bad++; $display("FAIL rint_after: got wr=%b res=%h want 0 fffffff6", ecall_write, ecall_result);
    end
  endtask

  task automatic test_read_char();
    run_call(32'd12, 32'h0, 1, 32'h1234_5678);
    total++; if (r_stall !== 3) begin bad++; $display("FAIL rchar_stall: got %0d want 3", r_stall); end
    total++; if (r_op !== 2'b11) begin bad++; $display("FAIL rchar_op: got %b want 11", r_op); end
    total++; if (r_wr !== 1 || r_res !== 32'h0000_0078) begin
      bad++; $display("FAIL rchar_wb: got wr=%0d res=%h want 1 00000078", r_wr, r_res);
    end
  endtask

  task automatic test_ignore_ack();
    @(posedge clk); #1;
    io_ack = 1'b1; io_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (io_req !== 1'b0 || ecall_write !== 1'b0 || stall !== 1'b0 || ecall_result !== 32'h0000_0078) begin
      bad++; $display("FAIL idle_ack: got req=%b wr=%b stall=%b res=%h want 0 0 0 00000078",
                      io_req, ecall_write, stall, ecall_result);
    end
    @(posedge clk); #1;
    io_ack = 1'b0;
  endtask

  task automatic test_bad_call();
    run_call(32'd99, 32'h0, -1, 32'h0);
    total++; if (r_stall !== 1 || r_req !== 0 || r_wr !== 0) begin
      bad++; $display("FAIL bad_svc: got stall=%0d req=%0d wr=%0d want 1 0 0", r_stall, r_req, r_wr);
    end
    total++; if (bad_call !== 1'b1) begin bad++; $display("FAIL bad_flag: got %b want 1", bad_call); end
    run_call(32'd1, 32'h7, 1, 32'h0);
    total++; if (bad_call !== 1'b1 || r_stall !== 2) begin
      bad++; $display("FAIL bad_sticky: got flag=%b stall=%0d want 1 2", bad_call, r_stall);
    end
  endtask

  task automatic test_reset_mid_req();
    int wr_seen;
    wr_seen = 0;
    @(posedge clk); #1;
    ecall_valid = 1'b1; a7_data = 32'd5;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (io_req !== 1'b1) begin bad++; $display("FAIL midrst_pre: got req=%b want 1", io_req); end
    @(posedge clk); #1;
    rst = 1'b1; ecall_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (io_req !== 1'b0 || stall !== 1'b0 || bad_call !== 1'b0) begin
      bad++; $display("FAIL midrst_post: got req=%b stall=%b bad=%b want 0 0 0", io_req, stall, bad_call);
    end
    for (int i = 0; i < 5; i++) begin
      io_ack = 1'b1; io_rdata = 32'h1111_2222;
      @(negedge clk);
      if (ecall_write) wr_seen++;
      @(posedge clk); #1;
    end
    io_ack = 1'b0;
    total++; if (wr_seen !== 0 || ecall_result !== 32'h0) begin
      bad++; $display("FAIL midrst_nowrite: got wr=%0d res=%h want 0 0", wr_seen, ecall_result);
    end
  endtask

  task automatic test_halt();
    int st, rq, wr;
    st = 0; rq = 0; wr = 0;
    @(posedge clk); #1;
    ecall_valid = 1'b1; a7_data = 32'd10;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) st++;
      if (io_req) rq++;
      if (ecall_write) wr++;
      @(posedge clk); #1;
    end
    ecall_valid = 1'b0;
    @(negedge clk);
    total++; if (st !== 100 || rq !== 0 || wr !== 0) begin
      bad++; $display("FAIL halt_hold: got stall=%0d req=%0d wr=%0d want 100 0 0", st, rq, wr);
    end
    total++; if (halted !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL halt_flag: got halted=%b stall=%b want 1 1", halted, stall);
    end
    do_reset();
    @(negedge clk);
    total++; if (halted !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL halt_reset: got halted=%b stall=%b want 0 0", halted, stall);
    end
    run_call(32'd1, 32'h3, 1, 32'h0);
    total++; if (r_stall !== 2) begin bad++; $display("FAIL halt_resume: got stall=%0d want 2", r_stall); end
  endtask

`ifdef ECALL_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_reset: got %b want 0", timeout); end
    run_call(32'd5, 32'h0, -1, 32'h0);
    total++; if (r_req !== 8 || r_stall !== 10) begin
      bad++; $display("FAIL to_read_cycles: got req=%0d stall=%0d want 8 10", r_req, r_stall);
    end
    total++; if (r_wr !== 1 || r_res !== 32'hFFFF_FFFF || timeout !== 1'b1) begin
      bad++; $display("FAIL to_read_wb: got wr=%0d res=%h to=%b want 1 ffffffff 1", r_wr, r_res, timeout);
    end
    run_call(32'd1, 32'h9, -1, 32'h0);
    total++; if (r_req !== 8 || r_stall !== 9 || r_wr !== 0) begin
      bad++; $display("FAIL to_write: got req=%0d stall=%0d wr=%0d want 8 9 0", r_req, r_stall, r_wr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_print_int();
    test_print_char();
    test_read_int();
    test_read_char();
    test_ignore_ack();
    test_bad_call();
    test_reset_mid_req();
    test_halt();
`ifdef ECALL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
